// File: rtl/fifo_threshold_pkg.sv
// Shared definitions for the threshold FIFO family.
// Holds the default geometry of one queue, the threshold width used by the
// flow-control FSM, and the queue index constants that match the bit
// positions of the FSM's empties/errors status vectors.
package fifo_threshold_pkg;

  localparam int FIFO_DATA_WIDTH   = 6;
  localparam int FIFO_DEPTH        = 16;
  localparam int FIFO_ADDR_WIDTH   = 4;
  localparam int FIFO_CNT_WIDTH    = 5;
  localparam int FIFO_THRESH_WIDTH = 5;

  // Queue instance index; each value is the bit this queue drives in the
  // FSM's empties/errors vectors.
  typedef enum logic [2:0] {
    Q_MAIN = 3'd0,
    Q_VC0  = 3'd1,
    Q_VC1  = 3'd2,
    Q_D0   = 3'd3,
    Q_D1   = 3'd4
  } queue_idx_e;

  localparam int NUM_QUEUES = 5;

endpackage

// File: rtl/fifo_threshold_if.sv
// Data/threshold/status bundle between a producer/consumer (master) and one
// fifo_threshold instance (slave).
//  push/data_in        write request and data
//  pop                 read request for the head entry
//  data_out/valid_out  registered read data and its one-cycle valid
//  thresh_load         capture low_thresh/high_thresh
//  count/empty/full/almost_empty/almost_full/error  status back to master
interface fifo_threshold_if
  import fifo_threshold_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
);

  logic                         push;
  logic [DATA_WIDTH-1:0]        data_in;
  logic                         pop;
  logic [DATA_WIDTH-1:0]        data_out;
  logic                         valid_out;
  logic                         thresh_load;
  logic [FIFO_THRESH_WIDTH-1:0] low_thresh;
  logic [FIFO_THRESH_WIDTH-1:0] high_thresh;
  logic [CNT_WIDTH-1:0]         count;
  logic                         empty;
  logic                         full;
  logic                         almost_empty;
  logic                         almost_full;
  logic                         error;

  modport master (
    output push, data_in, pop, thresh_load, low_thresh, high_thresh,
    input  data_out, valid_out, count, empty, full, almost_empty,
           almost_full, error
  );

  modport slave (
    input  push, data_in, pop, thresh_load, low_thresh, high_thresh,
    output data_out, valid_out, count, empty, full, almost_empty,
           almost_full, error
  );

endinterface

// File: rtl/fifo_threshold_mem.sv
// Storage array for fifo_threshold: DEPTH x DATA_WIDTH, one write port and
// one registered read port. No reset; contents are don't-care after reset.
//  clk      clock
//  wr_en    write wr_data at wr_addr
//  wr_addr  write address
//  wr_data  write data
//  rd_en    load rd_data from rd_addr
//  rd_addr  read address
//  rd_data  registered read data, holds while rd_en is low
module fifo_threshold_mem #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Array write and registered read; a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_threshold.sv
// Synchronous FIFO with run-time programmable almost-empty/almost-full
// thresholds. The control FSM loads the thresholds during INIT; this block
// applies them and reports empty/error status back.
//  clk    clock, rising edge
//  reset  synchronous, active-high
//  bus    fifo_threshold_if slave: push/data_in, pop/data_out/valid_out,
//         thresh_load/low_thresh/high_thresh, count and status flags
module fifo_threshold
  import fifo_threshold_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  fifo_threshold_if.slave bus
);

  logic [ADDR_WIDTH-1:0]        wr_ptr_r;
  logic [ADDR_WIDTH-1:0]        rd_ptr_r;
  logic [CNT_WIDTH-1:0]         count_r;
  logic [FIFO_THRESH_WIDTH-1:0] low_r;
  logic [FIFO_THRESH_WIDTH-1:0] high_r;
  logic                         valid_r;
  logic                         error_r;
  logic                         has_data_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  overflow_s;
  logic                  underflow_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  assign empty_s = (count_r == CNT_WIDTH'(0));
  assign full_s  = (count_r == CNT_WIDTH'(DEPTH));

  // A full FIFO still accepts a write when a read frees the head slot in the
  // same cycle; an empty FIFO never forwards a same-cycle write to the reader.
  assign wr_en_s     = bus.push && (!full_s || bus.pop);
  assign rd_en_s     = bus.pop && !empty_s;
  assign overflow_s  = bus.push && full_s && !bus.pop;
  assign underflow_s = bus.pop && empty_s;

  fifo_threshold_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en_s && !reset),
    .wr_addr (wr_ptr_r),
    .wr_data (bus.data_in),
    .rd_en   (rd_en_s && !reset),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Pointers, occupancy, read-valid, sticky error and threshold registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      low_r      <= '0;
      high_r     <= '0;
      valid_r    <= 1'b0;
      error_r    <= 1'b0;
      has_data_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= (wr_ptr_r == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_r + ADDR_WIDTH'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r   <= (rd_ptr_r == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_r + ADDR_WIDTH'(1);
        has_data_r <= 1'b1;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_WIDTH'(1);
        2'b01:   count_r <= count_r - CNT_WIDTH'(1);
        default: count_r <= count_r;
      endcase
      valid_r <= rd_en_s;
      error_r <= error_r || overflow_s || underflow_s;
      if (bus.thresh_load) begin
        low_r  <= bus.low_thresh;
        high_r <= bus.high_thresh;
      end
    end
  end

  // The memory read register has no reset, so data_out reads as zero until
  // the first read after reset has loaded it.
  assign bus.data_out     = has_data_r ? rd_data_s : '0;
  assign bus.valid_out    = valid_r;
  assign bus.count        = count_r;
  assign bus.empty        = empty_s;
  assign bus.full         = full_s;
  assign bus.almost_empty = (int'(count_r) <= int'(low_r));
  assign bus.almost_full  = (int'(count_r) >= int'(high_r));
  assign bus.error        = error_r;

endmodule

// File: tb/tb_fifo_threshold.sv
module tb_fifo_threshold;

  localparam int DW    = 6;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fifo_threshold_if #(.DATA_WIDTH(6), .CNT_WIDTH(5)) bus ();

  fifo_threshold dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: a queue of stored words plus flag state.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout;
  int            m_low;
  int            m_high;
  bit            m_err;
  bit            m_valid;
  bit            mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model applies the same inputs at the edge.
  task automatic cyc(input bit rst, input bit p, input logic [DW-1:0] d,
                     input bit r, input bit tl, input logic [4:0] lo,
                     input logic [4:0] hi);
    bit was_full;
    bit was_empty;
    reset           = rst;
    bus.push        = p;
    bus.data_in     = d;
    bus.pop         = r;
    bus.thresh_load = tl;
    bus.low_thresh  = lo;
    bus.high_thresh = hi;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_low   = 0;
      m_high  = 0;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_dout  = '0;
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      m_valid   = 1'b0;
      if (r && !was_empty) begin
        m_dout = m_q.pop_front();
        exp_q.push_back(m_dout);
        m_valid = 1'b1;
      end else if (r) begin
        m_err = 1'b1;
      end
      if (p) begin
        if (!was_full || r) m_q.push_back(d);
        else m_err = 1'b1;
      end
      if (tl) begin
        m_low  = int'(lo);
        m_high = int'(hi);
      end
    end
    #1;
  endtask

  task automatic idle();         cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0); endtask
  task automatic do_reset();     cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0); endtask
  task automatic wr(input logic [DW-1:0] d); cyc(1'b0, 1'b1, d, 1'b0, 1'b0, '0, '0); endtask
  task automatic rd();           cyc(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0); endtask
  task automatic wr_rd(input logic [DW-1:0] d); cyc(1'b0, 1'b1, d, 1'b1, 1'b0, '0, '0); endtask
  task automatic load(input logic [4:0] lo, input logic [4:0] hi);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1, lo, hi);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on valid_out.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", bus.count, m_q.size());
      check("empty", bus.empty, m_q.size() == 0);
      check("full", bus.full, m_q.size() == DEPTH);
      check("almost_empty", bus.almost_empty, m_q.size() <= m_low);
      check("almost_full", bus.almost_full, m_q.size() >= m_high);
      check("error", bus.error, m_err);
      check("valid_out", bus.valid_out, m_valid);
      check("data_out_hold", bus.data_out, m_dout);
      if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          check("read_data", bus.data_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // 1: fill with 0x01..0x10 under low=2/high=14, then drain in order
    do_reset();
    mon_en = 1'b1;
    load(5'd2, 5'd14);
    for (int i = 1; i <= 16; i++) wr(DW'(i));
    for (int i = 0; i < 16; i++) rd();
    idle();

    // 2: overflow drops 0x2A and sets error
    for (int i = 0; i < 16; i++) wr(DW'(i + 32));
    wr(6'h2A);
    idle();
    for (int i = 0; i < 16; i++) rd();
    idle();

    // 3: underflow, then push+pop on empty performs only the write
    do_reset();
    rd();
    wr_rd(6'h15);
    rd();
    idle();

    // 4: push+pop while full keeps count 16 without error
    do_reset();
    for (int i = 0; i < 16; i++) wr(DW'(i + 3));
    wr_rd(6'h3F);
    idle();
    for (int i = 0; i < 16; i++) rd();
    idle();

    // 5: crossed thresholds assert both flags, then neither
    do_reset();
    for (int i = 0; i < 5; i++) wr(DW'(i + 9));
    load(5'd6, 5'd5);
    idle();
    load(5'd1, 5'd15);
    idle();

    // 6: pointer wrap with paired traffic, then reset mid-stream
    do_reset();
    wr(6'h01);
    for (int i = 0; i < 20; i++) wr_rd(DW'(i + 2));
    wr(6'h30);
    do_reset();
    idle();

    // Random traffic with occasional threshold loads and resets
    for (int i = 0; i < 600; i++) begin
      bit p;
      bit r;
      bit tl;
      bit rs;
      p  = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 70 : 35));
      r  = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 35 : 70));
      tl = ($urandom_range(19) == 0);
      rs = ($urandom_range(149) == 0);
      cyc(rs, p, DW'($urandom), r, tl, 5'($urandom), 5'($urandom));
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
